// File: rtl/muldiv_pkg.sv
// Shared types and op encodings for the iterative multiply/divide sequencer.
// The ALU decoder reuses the MULDIV_OP_* constants.
package muldiv_pkg;

  localparam logic [1:0] MULDIV_OP_MUL   = 2'b00;
  localparam logic [1:0] MULDIV_OP_MULHU = 2'b01;
  localparam logic [1:0] MULDIV_OP_DIVU  = 2'b10;
  localparam logic [1:0] MULDIV_OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    MUL   = MULDIV_OP_MUL,
    MULHU = MULDIV_OP_MULHU,
    DIVU  = MULDIV_OP_DIVU,
    REMU  = MULDIV_OP_REMU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t op);
    return (op == DIVU) || (op == REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core and the multiply/divide sequencer.
interface muldiv_seq_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, op, src_a, src_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, src_a, src_b,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// hi is the upper accumulator half / partial remainder, lo the multiplier / dividend-quotient.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           nonneg;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    nonneg  = ~diff[WIDTH];
    if (is_div) begin
      hi_out = nonneg ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], nonneg};
    end else begin
      // Carry out of the add shifts down into the upper half.
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer, WIDTH cycles per operation.
// Optional macro MULDIV_EARLY_OUT_EN: zero-operand / divide-by-zero cases finish immediately.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  muldiv_state_t    state, state_nx;
  muldiv_op_t       op_q, op_in;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH-1:0] result_q, final_val, early_val;
  logic             accept, early, last, is_div_in, is_div_q;

  assign op_in    = muldiv_op_t'(bus.op);
  assign accept   = (state == IDLE) && bus.start && !bus.flush;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign is_div_q = op_is_div(op_q);

  always_comb begin
    is_div_in = op_is_div(op_in);
`ifdef MULDIV_EARLY_OUT_EN
    early = is_div_in ? (bus.src_b == '0) : ((bus.src_a == '0) || (bus.src_b == '0));
`else
    early = 1'b0;
`endif
    case (op_in)
      DIVU:    early_val = '1;
      REMU:    early_val = bus.src_a;
      default: early_val = '0;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .hi_in  (hi),
    .lo_in  (lo),
    .opnd   (opnd),
    .hi_out (hi_nx),
    .lo_out (lo_nx)
  );

  always_comb begin
    case (op_q)
      MUL, DIVU: final_val = lo_nx;
      default:   final_val = hi_nx;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = early ? DONE : RUN;
      RUN: begin
        if (bus.flush)  state_nx = IDLE;
        else if (last)  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= MUL;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q <= op_in;
      cnt  <= '0;
      hi   <= '0;
      lo   <= is_div_in ? bus.src_a : bus.src_b;
      opnd <= is_div_in ? bus.src_b : bus.src_a;
      if (early) result_q <= early_val;
    end else if (state == RUN) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + CW'(1);
      if (last && !bus.flush) result_q <= final_val;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE) && !bus.flush;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table through a result scoreboard,
// plus flush, mid-run reset, ignored-restart and start+flush sequences.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned exp_latency(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] && b == 0) return 0;
    if (!o[1] && (a == 0 || b == 0)) return 0;
`endif
    return W;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit push, output int unsigned n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    n = cyc;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done(input int unsigned n, input int unsigned exp_k);
    int unsigned k;
    logic [W-1:0] e;
    k = cyc - n;
    while (bus.done !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k = cyc - n;
    end
    chk("done_latency", k, exp_k);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("result", bus.result, e);
    last_result = e;
    @(posedge clk);
    #1;
    chk("busy_low_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int unsigned n;
    issue(o, a, b, exp, 1'b1, n);
    wait_done(n, exp_latency(o, a, b));
  endtask

  initial begin
    vec_t vecs[12];
    int unsigned n;
    bit saw_done;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'h0000_002A};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'h0000_000E};
    vecs[4]  = '{2'b11, 32'd100,        32'd7,          32'h0000_0002};
    vecs[5]  = '{2'b10, 32'h8000_0000,  32'd1,          32'h8000_0000};
    vecs[6]  = '{2'b10, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234};
    vecs[8]  = '{2'b00, 32'd0,          32'd5,          32'h0000_0000};
    vecs[9]  = '{2'b01, 32'h1234_5678,  32'd0,          32'h0000_0000};
    vecs[10] = '{2'b11, 32'd5,          32'd9,          32'h0000_0005};
    vecs[11] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;

    #12;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 300));
      run_op(ro, ra, rb, model(ro, ra, rb));
    end

    // Restart attempt with new operands mid-run must not disturb the first op.
    issue(2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b1, n);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.src_a = 32'd999;
    bus.src_b = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.src_a = 32'd1;
    bus.src_b = 32'd1;
    wait_done(n, W);

    // Flush during DIVU: no done pulse, result unchanged.
    issue(2'b10, 32'd1000, 32'd3, 32'd333, 1'b0, n);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("flush_no_done", saw_done, 0);
    chk("flush_result_kept", bus.result, last_result);

    // Reset mid-run: outputs clear without waiting for a clock edge.
    issue(2'b10, 32'd1000, 32'd3, 32'd333, 1'b0, n);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_busy", bus.busy, 0);
    chk("async_reset_done", bus.done, 0);
    chk("async_reset_result", bus.result, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset_idle", bus.busy, 0);
    chk("after_reset_result", bus.result, 0);

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b00;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("start_flush_no_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("start_flush_still_idle", bus.busy, 0);

    run_op(2'b11, 32'd100, 32'd7, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
